// File: rtl/led_sequencer_if.sv
// Bundle of the sequencer's board-facing signals: raw buttons and mode/direction in,
// LED drive and status out.
interface led_sequencer_if #(
    parameter int unsigned N_CH = 4
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  btn_n;
    logic             mode_auto;
    logic             dir;
    logic [N_CH-1:0]  led;
    logic [IDX_W-1:0] idx;
    logic             step;
    logic             paused;

    modport master (
        output btn_n, mode_auto, dir,
        input  led, idx, step, paused
    );

    modport slave (
        input  btn_n, mode_auto, dir,
        output led, idx, step, paused
    );
endinterface

// File: rtl/led_sequencer.sv
// One-hot LED sequencer: debounced button presses of the lit channel (or a timer in auto
// mode) step the lit LED forward or backward; a press in auto mode pauses/resumes.
module led_sequencer #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 60000,
    parameter int unsigned AUTO_PERIOD     = 3000000
) (
    input logic            clk,
    input logic            rst,
    led_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TM_W  = $clog2(AUTO_PERIOD + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(AUTO_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        StManual,
        StAuto,
        StPaused
    } state_e;

    // ------------------------------------------------------------------
    // Input path: synchroniser, debouncer, falling-edge press detect
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] deb_q, deb_d;
    logic [N_CH-1:0] deb_prev_q;
    logic [N_CH-1:0] press_q;
    logic [DB_W-1:0] db_cnt_q [N_CH];
    logic [DB_W-1:0] db_cnt_d [N_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus.btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Counter runs only while the synced level disagrees with the accepted one.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_CH; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q      <= '1;
            deb_prev_q <= '1;
            press_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_prev_q & ~deb_q;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_next;
    logic [N_CH-1:0]  led_q, led_next;
    logic [TM_W-1:0]  timer_q;
    logic             step_q;
    logic             press_cur;
    logic             timer_exp;
    logic             advance;
    logic             timer_clr;
    logic             timer_inc;

    // led_q is one-hot, so masking with it selects the press of the lit channel.
    assign press_cur = |(press_q & led_q);
    assign timer_exp = (timer_q == TM_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StManual;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StManual: begin
                if (bus.mode_auto) state_d = StAuto;
            end
            StAuto: begin
                if (!bus.mode_auto)  state_d = StManual;
                else if (press_cur)  state_d = StPaused;
            end
            StPaused: begin
                if (!bus.mode_auto)  state_d = StManual;
                else if (press_cur)  state_d = StAuto;
            end
            default: state_d = StManual;
        endcase
    end

    // A mode change takes priority over presses and expiry in the cycle it is seen.
    always_comb begin
        advance   = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        case (state_q)
            StManual: begin
                timer_clr = 1'b1;
                advance   = !bus.mode_auto && press_cur;
            end
            StAuto: begin
                if (!bus.mode_auto) begin
                    timer_clr = 1'b1;
                end else if (!press_cur) begin
                    if (timer_exp) begin
                        advance   = 1'b1;
                        timer_clr = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
            end
            StPaused: begin
                if (!bus.mode_auto) timer_clr = 1'b1;
            end
            default: timer_clr = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Index / LED / timer datapath
    // ------------------------------------------------------------------
    always_comb begin
        if (bus.dir) begin
            idx_next = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
        end else begin
            idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        led_next = {{(N_CH-1){1'b0}}, 1'b1} << idx_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            led_q   <= {{(N_CH-1){1'b0}}, 1'b1};
            step_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            step_q <= advance;
            if (advance) begin
                idx_q <= idx_next;
                led_q <= led_next;
            end
            if (timer_clr) begin
                timer_q <= '0;
            end else if (timer_inc) begin
                timer_q <= timer_q + TM_W'(1);
            end
        end
    end

    assign bus.led    = led_q;
    assign bus.idx    = idx_q;
    assign bus.step   = step_q;
    assign bus.paused = (state_q == StPaused);

    led_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot(led_q));

endmodule

// File: tb/tb_led_sequencer.sv
// Randomised bench for led_sequencer: a cycle-level behavioural model built from the
// window/priority rules runs alongside the DUT; scenario tasks add directed checks.
module tb_led_sequencer;
    localparam int unsigned N_CH = 4;
    localparam int unsigned DEB  = 4;
    localparam int unsigned AP   = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] btn_n = '1;
    logic            mode_auto = 1'b0;
    logic            dir = 1'b0;

    led_sequencer_if #(.N_CH(N_CH)) bus ();

    assign bus.btn_n     = btn_n;
    assign bus.mode_auto = mode_auto;
    assign bus.dir       = dir;

    led_sequencer #(
        .N_CH           (N_CH),
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_PERIOD    (AP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int  m_idx;
    int  m_timer;
    bit  m_auto, m_paused, m_step;
    bit  m_deb [N_CH];
    bit  s1 [N_CH];
    bit  s2 [N_CH];
    bit  pend1 [N_CH];
    bit  pend2 [N_CH];
    bit  win [N_CH][$];

    // Observation bookkeeping
    int          cyc = 0;
    int          div_cnt = 0;
    int          step_seen = 0;
    int          fd_cyc, fd_idx, fd_widx;
    logic [3:0]  fd_led;
    logic        fd_step, fd_paused, fd_wstep, fd_wpaused;

    function automatic void model_reset();
        m_idx = 0; m_timer = 0; m_auto = 0; m_paused = 0; m_step = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_deb[c] = 1; s1[c] = 1; s2[c] = 1; pend1[c] = 0; pend2[c] = 0;
            win[c] = {};
            for (int k = 0; k < DEB; k++) win[c].push_back(1'b1);
        end
    endfunction

    // One clock edge of the model; inputs are the values present before the edge.
    function automatic void model_step(input logic [N_CH-1:0] raw, input logic ma,
                                       input logic dr);
        bit pev, adv, flip;
        pev = pend2[m_idx];
        adv = 0;
        if (ma != m_auto) begin
            m_auto = ma; m_timer = 0; m_paused = 0;
        end else if (!m_auto) begin
            adv = pev;
        end else if (!m_paused) begin
            if (pev) m_paused = 1;
            else if (m_timer == AP - 1) begin adv = 1; m_timer = 0; end
            else m_timer++;
        end else if (pev) begin
            m_paused = 0;
        end
        if (adv) m_idx = dr ? (m_idx + N_CH - 1) % N_CH : (m_idx + 1) % N_CH;
        m_step = adv;
        for (int c = 0; c < N_CH; c++) begin
            pend2[c] = pend1[c];
            pend1[c] = 0;
            // New level accepted once the last DEB synced samples all disagree with it.
            win[c].push_back(s2[c]);
            if (win[c].size() > DEB) void'(win[c].pop_front());
            flip = 1;
            foreach (win[c][k]) if (win[c][k] == m_deb[c]) flip = 0;
            if (flip) begin
                m_deb[c] = ~m_deb[c];
                if (!m_deb[c]) pend1[c] = 1;
            end
            s2[c] = s1[c];
            s1[c] = raw[c];
        end
    endfunction

    task automatic tick();
        logic [N_CH-1:0] raw, wled;
        logic ma, dr;
        @(posedge clk);
        raw = btn_n; ma = mode_auto; dr = dir;
        if (rst) model_reset();
        else model_step(raw, ma, dr);
        #1;
        cyc++;
        wled = '0;
        wled[m_idx] = 1'b1;
        if (bus.idx !== 2'(m_idx) || bus.led !== wled || bus.step !== m_step ||
            bus.paused !== m_paused) begin
            if (div_cnt == 0) begin
                fd_cyc = cyc; fd_idx = int'(bus.idx); fd_led = bus.led;
                fd_step = bus.step; fd_paused = bus.paused;
                fd_widx = m_idx; fd_wstep = m_step; fd_wpaused = m_paused;
            end
            div_cnt++;
        end
        if (bus.step === 1'b1) step_seen++;
    endtask

    task automatic tap(input int ch, input int hold, input int gap);
        btn_n[ch] = 1'b0;
        repeat (hold) tick();
        btn_n[ch] = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        div_cnt = 0;
        repeat (3) tick();
        total++; if (bus.idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", bus.idx); end
        total++; if (bus.led !== 4'b0001) begin bad++; $display("FAIL reset_led: got %b want 0001", bus.led); end
        total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL reset_step: got %b want 0", bus.step); end
        total++; if (bus.paused !== 1'b0) begin bad++; $display("FAIL reset_paused: got %b want 0", bus.paused); end
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if (div_cnt !== 0) begin
            bad++;
            $display("FAIL reset_model: %0d diverging cycles, first at %0d got idx=%0d step=%b want idx=%0d step=%b",
                     div_cnt, fd_cyc, fd_idx, fd_step, fd_widx, fd_wstep);
        end
    endtask

    task automatic test_single_press();
        int first = -1;
        div_cnt = 0; step_seen = 0;
        btn_n[0] = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (first < 0 && bus.idx !== 2'd0) first = t;
        end
        total++; if (first !== 8) begin bad++; $display("FAIL press_latency: got %0d want 8", first); end
        total++; if (bus.idx !== 2'd1) begin bad++; $display("FAIL press_idx: got %0d want 1", bus.idx); end
        total++; if (bus.led !== 4'b0010) begin bad++; $display("FAIL press_led: got %b want 0010", bus.led); end
        total++; if (step_seen !== 1) begin bad++; $display("FAIL press_steps: got %0d want 1", step_seen); end
        step_seen = 0;
        repeat (20) tick();
        total++; if (step_seen !== 0) begin bad++; $display("FAIL held_steps: got %0d want 0", step_seen); end
        btn_n[0] = 1'b1;
        repeat (10) tick();
        total++;
        if (div_cnt !== 0) begin
            bad++;
            $display("FAIL press_model: %0d diverging cycles, first at %0d got idx=%0d led=%b step=%b want idx=%0d step=%b",
                     div_cnt, fd_cyc, fd_idx, fd_led, fd_step, fd_widx, fd_wstep);
        end
    endtask

    task automatic test_other_channels();
        div_cnt = 0; step_seen = 0;
        tap(3, 10, 10);
        tap(0, 10, 10);
        total++; if (bus.idx !== 2'd1) begin bad++; $display("FAIL other_idx: got %0d want 1", bus.idx); end
        total++; if (step_seen !== 0) begin bad++; $display("FAIL other_steps: got %0d want 0", step_seen); end
        tap(1, 10, 10);
        total++; if (bus.idx !== 2'd2) begin bad++; $display("FAIL own_idx: got %0d want 2", bus.idx); end
        total++;
        if (div_cnt !== 0) begin
            bad++;
            $display("FAIL other_model: %0d diverging cycles, first at %0d got idx=%0d want idx=%0d",
                     div_cnt, fd_cyc, fd_idx, fd_widx);
        end
    endtask

    task automatic test_dir_wrap();
        div_cnt = 0;
        dir = 1'b0;
        tap(2, 10, 10);
        tap(3, 10, 10);
        total++; if (bus.idx !== 2'd0) begin bad++; $display("FAIL fwd_wrap_idx: got %0d want 0", bus.idx); end
        dir = 1'b1;
        tap(0, 10, 10);
        total++; if (bus.idx !== 2'd3) begin bad++; $display("FAIL back_wrap_idx: got %0d want 3", bus.idx); end
        total++; if (bus.led !== 4'b1000) begin bad++; $display("FAIL back_wrap_led: got %b want 1000", bus.led); end
        dir = 1'b0;
        tap(3, 10, 10);
        total++; if (bus.idx !== 2'd0) begin bad++; $display("FAIL fwd_wrap2_idx: got %0d want 0", bus.idx); end
        total++;
        if (div_cnt !== 0) begin
            bad++;
            $display("FAIL dir_model: %0d diverging cycles, first at %0d got idx=%0d want idx=%0d",
                     div_cnt, fd_cyc, fd_idx, fd_widx);
        end
    endtask

    task automatic test_bounce();
        div_cnt = 0; step_seen = 0;
        for (int k = 0; k < 16; k++) begin
            btn_n[0] = ~btn_n[0];
            repeat (2) tick();
        end
        btn_n[0] = 1'b1;
        repeat (10) tick();
        total++; if (bus.idx !== 2'd0) begin bad++; $display("FAIL bounce_idx: got %0d want 0", bus.idx); end
        total++; if (step_seen !== 0) begin bad++; $display("FAIL bounce_steps: got %0d want 0", step_seen); end
    endtask

    task automatic test_random_manual();
        int cur, ch, g;
        div_cnt = 0;
        cur = m_idx;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                g = $urandom_range(0, N_CH - 1);
                btn_n[g] = 1'b0;
                repeat ($urandom_range(1, DEB - 1)) tick();
                btn_n[g] = 1'b1;
                repeat (4) tick();
            end
            dir = 1'($urandom_range(0, 1));
            ch  = ($urandom_range(0, 1) == 1) ? m_idx : int'($urandom_range(0, N_CH - 1));
            if (ch == cur) cur = dir ? (cur + N_CH - 1) % N_CH : (cur + 1) % N_CH;
            tap(ch, $urandom_range(6, 14), $urandom_range(8, 12));
        end
        dir = 1'b0;
        total++; if (bus.idx !== 2'(cur)) begin bad++; $display("FAIL rand_idx: got %0d want %0d", bus.idx, cur); end
        total++;
        if (div_cnt !== 0) begin
            bad++;
            $display("FAIL rand_model: %0d diverging cycles, first at %0d got idx=%0d led=%b step=%b want idx=%0d step=%b",
                     div_cnt, fd_cyc, fd_idx, fd_led, fd_step, fd_widx, fd_wstep);
        end
    endtask

    task automatic test_auto();
        int first = -1;
        int cur;
        logic [1:0] frozen;
        div_cnt = 0;
        for (int n = 0; n < N_CH && m_idx != 0; n++) tap(m_idx, 10, 10);
        step_seen = 0;
        mode_auto = 1'b1;
        for (int t = 1; t <= 41; t++) begin
            tick();
            if (first < 0 && bus.step === 1'b1) first = t;
        end
        total++; if (first !== 11) begin bad++; $display("FAIL auto_first_step: got %0d want 11", first); end
        total++; if (step_seen !== 4) begin bad++; $display("FAIL auto_steps: got %0d want 4", step_seen); end
        total++; if (bus.idx !== 2'd0) begin bad++; $display("FAIL auto_idx: got %0d want 0", bus.idx); end
        cur = m_idx;
        btn_n[cur] = 1'b0;
        for (int n = 0; n < 12 && bus.paused !== 1'b1; n++) tick();
        total++; if (bus.paused !== 1'b1) begin bad++; $display("FAIL pause_set: got %b want 1", bus.paused); end
        btn_n[cur] = 1'b1;
        frozen = bus.idx;
        step_seen = 0;
        repeat (50) tick();
        total++; if (bus.idx !== frozen) begin bad++; $display("FAIL pause_idx: got %0d want %0d", bus.idx, frozen); end
        total++; if (step_seen !== 0) begin bad++; $display("FAIL pause_steps: got %0d want 0", step_seen); end
        btn_n[cur] = 1'b0;
        for (int n = 0; n < 12 && bus.paused !== 1'b0; n++) tick();
        total++; if (bus.paused !== 1'b0) begin bad++; $display("FAIL pause_clear: got %b want 0", bus.paused); end
        btn_n[cur] = 1'b1;
        step_seen = 0;
        repeat (25) tick();
        total++; if (step_seen < 2) begin bad++; $display("FAIL resume_steps: got %0d want >=2", step_seen); end
        total++;
        if (div_cnt !== 0) begin
            bad++;
            $display("FAIL auto_model: %0d diverging cycles, first at %0d got idx=%0d step=%b paused=%b want idx=%0d step=%b paused=%b",
                     div_cnt, fd_cyc, fd_idx, fd_step, fd_paused, fd_widx, fd_wstep, fd_wpaused);
        end
    endtask

    task automatic test_expiry_collision();
        int cur;
        div_cnt = 0;
        for (int n = 0; n < 30 && !(m_timer == 2 && !m_paused); n++) tick();
        total++;
        if (!(m_timer == 2 && !m_paused)) begin
            bad++; $display("FAIL collide_setup: timer %0d paused %0b, wanted timer 2 running", m_timer, m_paused);
        end
        cur = m_idx;
        step_seen = 0;
        btn_n[cur] = 1'b0;
        repeat (8) tick();
        total++; if (bus.paused !== 1'b1) begin bad++; $display("FAIL collide_paused: got %b want 1", bus.paused); end
        total++; if (step_seen !== 0) begin bad++; $display("FAIL collide_step: got %0d want 0", step_seen); end
        total++; if (bus.idx !== 2'(cur)) begin bad++; $display("FAIL collide_idx: got %0d want %0d", bus.idx, cur); end
        btn_n[cur] = 1'b1;
        repeat (20) tick();
        btn_n[cur] = 1'b0;
        for (int n = 0; n < 12 && bus.paused !== 1'b0; n++) tick();
        tick();
        total++; if (bus.step !== 1'b1) begin bad++; $display("FAIL resume_expiry: got %b want 1", bus.step); end
        btn_n[cur] = 1'b1;
        repeat (10) tick();
        total++;
        if (div_cnt !== 0) begin
            bad++;
            $display("FAIL collide_model: %0d diverging cycles, first at %0d got idx=%0d step=%b paused=%b want idx=%0d step=%b paused=%b",
                     div_cnt, fd_cyc, fd_idx, fd_step, fd_paused, fd_widx, fd_wstep, fd_wpaused);
        end
    endtask

    task automatic test_reset_midrun();
        div_cnt = 0;
        for (int n = 0; n < 60 && m_idx != 2; n++) tick();
        total++; if (bus.idx !== 2'd2) begin bad++; $display("FAIL midrun_setup: got idx %0d want 2", bus.idx); end
        #3 rst = 1'b1;
        model_reset();
        #1;
        total++; if (bus.idx !== 2'd0) begin bad++; $display("FAIL async_idx: got %0d want 0", bus.idx); end
        total++; if (bus.led !== 4'b0001) begin bad++; $display("FAIL async_led: got %b want 0001", bus.led); end
        total++; if (bus.paused !== 1'b0) begin bad++; $display("FAIL async_paused: got %b want 0", bus.paused); end
        total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL async_step: got %b want 0", bus.step); end
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        total++;
        if (div_cnt !== 0) begin
            bad++;
            $display("FAIL midrun_model: %0d diverging cycles, first at %0d got idx=%0d step=%b want idx=%0d step=%b",
                     div_cnt, fd_cyc, fd_idx, fd_step, fd_widx, fd_wstep);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_other_channels();
        test_dir_wrap();
        test_bounce();
        test_random_manual();
        test_auto();
        test_expiry_collision();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
